// File: rtl/p2s_param.sv
// p2s_param: parameterised parallel-to-serial shifter with per-bit timing, MSB/LSB order and abort
module p2s_param #(
  parameter int   DATA_W   = 64,
  parameter int   CNT_W    = 7,
  parameter int   TICK_W   = 8,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_parallel,
  input  logic [CNT_W-1:0]  i_len,
  input  logic [TICK_W-1:0] i_bit_ticks,
  input  logic              i_msb_first,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_serial_out,
  output logic              o_bit_strobe,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_bit_idx
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t st, st_n;
  logic [DATA_W-1:0] sh, sh_n, ld;
  logic [CNT_W-1:0] cnt, cnt_n, idx_n, len_e;
  logic [TICK_W-1:0] tmr, tmr_n, tks, tks_n;
  logic msb, msb_n, ser_n, stb_n, busy_n, done_n;
  assign len_e = (i_len == '0 || i_len > CNT_W'(DATA_W)) ? CNT_W'(DATA_W) : i_len;
  // MSB-first words are left-aligned so the current bit always sits at the top
  assign ld = i_parallel << (CNT_W'(DATA_W) - len_e);
  always_comb begin
    st_n = st;
    sh_n = sh;
    cnt_n = cnt;
    tmr_n = tmr;
    tks_n = tks;
    msb_n = msb;
    ser_n = o_serial_out;
    stb_n = 1'b0;
    busy_n = o_busy;
    done_n = 1'b0;
    idx_n = o_bit_idx;
    if (st == IDLE) begin
      if (i_start && !i_abort) begin
        st_n = SHIFT;
        sh_n = i_msb_first ? ld : i_parallel;
        cnt_n = len_e - 1'b1;
        tmr_n = i_bit_ticks;
        tks_n = i_bit_ticks;
        msb_n = i_msb_first;
        ser_n = i_msb_first ? ld[DATA_W-1] : i_parallel[0];
        stb_n = 1'b1;
        busy_n = 1'b1;
        idx_n = '0;
      end
    end else if (i_abort || (tmr == '0 && cnt == '0)) begin
      st_n = IDLE;
      sh_n = '0;
      cnt_n = '0;
      tmr_n = '0;
      ser_n = IDLE_LVL;
      busy_n = 1'b0;
      idx_n = '0;
      done_n = !i_abort;
    end else if (tmr != '0) begin
      tmr_n = tmr - 1'b1;
    end else begin
      sh_n = msb ? sh << 1 : sh >> 1;
      ser_n = msb ? sh[DATA_W-2] : sh[1];
      stb_n = 1'b1;
      cnt_n = cnt - 1'b1;
      idx_n = o_bit_idx + 1'b1;
      tmr_n = tks;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      sh <= '0;
      cnt <= '0;
      tmr <= '0;
      tks <= '0;
      msb <= 1'b0;
      o_serial_out <= IDLE_LVL;
      o_bit_strobe <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_bit_idx <= '0;
    end else begin
      st <= st_n;
      sh <= sh_n;
      cnt <= cnt_n;
      tmr <= tmr_n;
      tks <= tks_n;
      msb <= msb_n;
      o_serial_out <= ser_n;
      o_bit_strobe <= stb_n;
      o_busy <= busy_n;
      o_done <= done_n;
      o_bit_idx <= idx_n;
    end
  end
endmodule

// File: tb/tb_p2s_param.sv
// tb_p2s_param: scoreboard bench; stimulus pushes expected bits/done times, a monitor pops on strobe/done
module tb_p2s_param;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] i_parallel = '0;
  logic [3:0] i_len = '0;
  logic [7:0] i_bit_ticks = '0;
  logic i_msb_first = 1'b0, i_start = 1'b0, i_abort = 1'b0;
  logic o_serial_out, o_bit_strobe, o_busy, o_done;
  logic [3:0] o_bit_idx;
  typedef struct {logic b; int idx; int cyc;} exp_t;
  exp_t q[$];
  int dq[$];
  int tests = 0, errs = 0, cyc = 0, tt;
  logic mon = 1'b0, lastb = 1'b1;
  int lasti = 0;
  p2s_param #(.DATA_W(8), .CNT_W(4), .TICK_W(8), .IDLE_LVL(1'b1)) dut (
    .clk(clk), .reset(reset), .i_parallel(i_parallel), .i_len(i_len), .i_bit_ticks(i_bit_ticks),
    .i_msb_first(i_msb_first), .i_start(i_start), .i_abort(i_abort), .o_serial_out(o_serial_out),
    .o_bit_strobe(o_bit_strobe), .o_busy(o_busy), .o_done(o_done), .o_bit_idx(o_bit_idx));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int a, input int e);
    tests++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, a, e);
    end
  endtask
  always @(negedge clk) if (mon) begin
    exp_t e;
    if (o_bit_strobe) begin
      chk("strobe_expected", int'(q.size() > 0), 1);
      chk("strobe_busy", int'(o_busy), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("bit", int'(o_serial_out), int'(e.b));
        chk("bit_idx", int'(o_bit_idx), e.idx);
        chk("strobe_cyc", cyc, e.cyc);
        lastb = e.b;
        lasti = e.idx;
      end
    end else if (o_busy) begin
      chk("hold_bit", int'(o_serial_out), int'(lastb));
      chk("hold_idx", int'(o_bit_idx), lasti);
    end else begin
      chk("idle_ser", int'(o_serial_out), 1);
      chk("idle_idx", int'(o_bit_idx), 0);
    end
    if (o_done) begin
      chk("done_expected", int'(dq.size() > 0), 1);
      if (dq.size() > 0) chk("done_cyc", cyc, dq.pop_front());
    end
  end
  // seq[k] is the k-th bit expected on the line; nb bits are expected, done only if dn
  task automatic go(input logic [7:0] d, input logic [3:0] l, input logic [7:0] t, input logic m,
                    input logic [7:0] seq, input int n, input int nb, input bit dn, input bit hold,
                    output int tstart);
    int p = int'(t) + 1;
    tstart = cyc + 1;
    i_parallel = d; i_len = l; i_bit_ticks = t; i_msb_first = m; i_start = 1'b1;
    for (int k = 0; k < nb; k++) q.push_back('{seq[k], k, tstart + k * p});
    if (dn) dq.push_back(tstart + n * p);
    @(negedge clk);
    if (!hold) i_start = 1'b0;
  endtask
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic drain();
    int b = 0;
    while ((q.size() > 0 || dq.size() > 0 || o_busy) && b < 300) begin
      @(negedge clk);
      b++;
    end
    chk("drain_timeout", int'(b < 300), 1);
    @(negedge clk);
  endtask
  task automatic chk_idle(input string nm);
    chk({nm, "_busy"}, int'(o_busy), 0);
    chk({nm, "_ser"}, int'(o_serial_out), 1);
    chk({nm, "_stb"}, int'(o_bit_strobe), 0);
    chk({nm, "_done"}, int'(o_done), 0);
    chk({nm, "_idx"}, int'(o_bit_idx), 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;
    mon = 1'b1;
    @(negedge clk);
    go(8'hA5, 4'd8, 8'd2, 1'b0, 8'hA5, 8, 8, 1'b1, 1'b0, tt);
    wait_cyc(tt + 7);
    i_parallel = 8'h00; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    drain();
    go(8'hA5, 4'd4, 8'd2, 1'b1, 8'h0A, 4, 4, 1'b1, 1'b0, tt);
    drain();
    go(8'h3C, 4'd0, 8'd0, 1'b0, 8'h3C, 8, 8, 1'b1, 1'b0, tt);
    drain();
    go(8'h81, 4'd12, 8'd0, 1'b1, 8'h81, 8, 8, 1'b1, 1'b0, tt);
    drain();
    go(8'hA5, 4'd8, 8'd1, 1'b0, 8'hA5, 8, 4, 1'b0, 1'b0, tt);
    wait_cyc(tt + 6);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk_idle("abort");
    i_start = 1'b1; i_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;
    chk("abort_start_busy", int'(o_busy), 0);
    go(8'h3C, 4'd0, 8'd0, 1'b0, 8'h3C, 8, 8, 1'b1, 1'b0, tt);
    drain();
    go(8'h3C, 4'd4, 8'd1, 1'b0, 8'h0C, 4, 4, 1'b1, 1'b1, tt);
    wait_cyc(tt + 3);
    i_parallel = 8'hFF; i_len = 4'd2; i_msb_first = 1'b1;
    wait_cyc(tt + 8);
    go(8'hA5, 4'd4, 8'd0, 1'b1, 8'h0A, 4, 4, 1'b1, 1'b0, tt);
    drain();
    go(8'hA5, 4'd8, 8'd1, 1'b0, 8'hA5, 8, 6, 1'b0, 1'b0, tt);
    wait_cyc(tt + 10);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("midreset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("leftover_bits", q.size(), 0);
    chk("leftover_done", dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
